mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide scheduler that sits beside the ALU in the execute stage.
- Accepts one MDU operation per issue and produces the result after a fixed latency.
- Holds the architectural HI/LO registers and exports a busy handshake to the hazard unit.
- The hazard unit stalls any MDU instruction while `start | busy` is high.

Parameters:
- MULT_LAT, 5, cycles from start to HI/LO commit for MULT/MULTU (and MADD); legal range ≥1.
- DIV_LAT, 10, cycles from start to HI/LO commit for DIV/DIVU; legal range ≥1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  issue strobe, qualified by op.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD (optional feature only), 111 no-op.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  long operation in flight.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts the operation; no commit occurs.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE + start + long op (MULT/MULTU/DIV/DIVU/MADD):
  - Compute the 64-bit result from A/B at the start edge and latch it into pending {hi,lo}.
  - Load counter = LAT−1 and go to RUN.
- RUN: decrement counter each cycle. At the edge where counter==0: HI/LO ← pending, return to IDLE.
- Timing: start sampled in cycle t → busy=1 in cycles t+1 … t+LAT → new HI/LO and busy=0 visible from cycle t+LAT+1.
- IDLE + start + MTHI/MTLO: HI←A or LO←A at that edge, visible next cycle. busy stays 0.
- Start while busy=1: ignored completely for every op, including MTHI/MTLO. The hazard unit guarantees this does not occur; the bench checks it anyway.
- op=111, or op=110 with the feature disabled: no-op, no state change.
- Arithmetic:
  - MULT: signed 32×32→64, HI=upper word, LO=lower word.
  - MULTU: unsigned 32×32→64, HI=upper word, LO=lower word.
  - DIV: signed, quotient truncated toward zero into LO; remainder into HI, taking the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero (B=0): full DIV_LAT busy period still runs; HI/LO are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No exception.
- HI/LO change only at commit, MTHI/MTLO, or reset. They are readable (mfhi/mflo) at all times; reads during busy return the old values.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 110 = MADD, {HI,LO} ← {HI,LO} + signed(A)×signed(B).
  - Uses MULT_LAT.
  - The accumulate base is HI/LO as sampled at the start edge.
  - Wraps modulo 2^64.
- Undefined: op 110 is a no-op and no MADD logic is synthesized.

Decomposition:
- Shared package/header: op codes (MDU_MULT … MDU_NOP), default latency constants, state encodings for IDLE/RUN.
- One natural sub-module, mdu_arith: combinational; takes op, A, B, and current {HI,LO}; returns the 64-bit result and a div-by-zero flag.
- mdu_ctrl owns the FSM, counter, pending register and HI/LO.

Test Plan:
1. MULT, A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
3. DIV, A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
4. DIVU, A=5, B=0, with prior HI=0x11, LO=0x22 → busy 10 cycles; HI/LO remain 0x11/0x22.
5. MTLO with A=0x1234 while idle → LO=0x1234 next cycle, busy stays 0. MTHI issued during a running MULT → ignored, the MULT result commits normally.
6. Reset asserted in cycle 3 of a DIV → next cycle busy=0, HI=LO=0, and no commit at the original deadline. With MDU_MADD_EN: HI/LO=0/5, MADD A=2, B=3 → LO=11 after 5 cycles.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDU op codes, default latencies and FSM encodings.
// Optional MADD (op 110) is enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;
    localparam logic [2:0] MDU_MADD  = 3'b110;
    localparam logic [2:0] MDU_NOP   = 3'b111;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_long(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return !op[2] || op == MDU_MADD;
`else
        return !op[2];
`endif
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit multiply/divide result and div-by-zero flag.
// With MDU_MADD_EN the current {HI,LO} is taken in as the MADD accumulate base.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        dz
`ifdef MDU_MADD_EN
    ,
    input  logic [63:0] hilo
`endif
);

    logic signed [63:0] smul;
    logic        [63:0] umul;
    logic signed [31:0] sd;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic        [31:0] ud;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               bz;
    logic               ov;

    assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul = {32'b0, a} * {32'b0, b};
    assign bz   = b == 32'd0;
    assign ov   = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    // Overflow and zero divisors are steered to 1: min/1 already yields the required q=min, r=0
    assign sd   = (bz || ov) ? 32'sd1 : $signed(b);
    assign sq   = $signed(a) / sd;
    assign sr   = $signed(a) % sd;
    assign ud   = bz ? 32'd1 : b;
    assign uq   = a / ud;
    assign ur   = a % ud;
    assign dz   = bz && is_div(op);

    always_comb begin
        res = op == MDU_DIV   ? {sr, sq} :
              op == MDU_DIVU  ? {ur, uq} :
              op == MDU_MULTU ? umul     : smul;
`ifdef MDU_MADD_EN
        if (op == MDU_MADD)
            res = hilo + smul;
`endif
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MUL/DIV scheduler owning HI/LO, busy FSM and pending result.
// Define MDU_MADD_EN to enable op 110 (MADD); otherwise it is a no-op.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = 16;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lat_m1;
    logic [63:0]   res;
    logic [63:0]   pend;
    logic          dz;
    logic          pend_dz;

    mdu_arith u_arith (
        .op  (op),
        .a   (A),
        .b   (B),
        .res (res),
        .dz  (dz)
`ifdef MDU_MADD_EN
        ,
        .hilo({HI, LO})
`endif
    );

    assign busy   = state == ST_RUN;
    assign lat_m1 = is_div(op) ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);

    // Starts are only honoured in IDLE; everything issued while RUN is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (state == ST_IDLE) begin
            if (start && is_long(op)) begin
                pend    <= res;
                pend_dz <= dz;
                cnt     <= lat_m1;
                state   <= ST_RUN;
            end else if (start && op == MDU_MTHI) begin
                HI <= A;
            end else if (start && op == MDU_MTLO) begin
                LO <= A;
            end
        end else if (cnt == '0) begin
            state <= ST_IDLE;
            if (!pend_dz)
                {HI, LO} <= pend;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule
